// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-neuron blocks.
//   state_t   : neuron state encoding (INTEG = 1'b0, REFRACT = 1'b1)
//   sum_width : width of an event-masked weight sum that cannot overflow
//   sat_add   : unsigned add clamped at 2^w-1 (operands up to 62 bits wide)
// ---------------------------------------------------------------------------
package snn_pkg;

  typedef enum logic {
    INTEG   = 1'b0,
    REFRACT = 1'b1
  } state_t;

  localparam int SAT_W = 64;

  function automatic int sum_width(input int s, input int w);
    return w + $clog2(s + 1);
  endfunction

  // Both operands are below 2^w with w <= 62, so the 64-bit sum never wraps
  // before the clamp is applied.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int               w);
    logic [SAT_W-1:0] lim;
    logic [SAT_W-1:0] r;
    lim = (64'd1 << w) - 64'd1;
    r   = a + b;
    if (r > lim) r = lim;
    return r;
  endfunction

endpackage

// File: rtl/weighted_sum.sv
// ---------------------------------------------------------------------------
// weighted_sum
// Combinational event-masked weight sum using a balanced adder tree.
// Ports:
//   i_event  [P_S]           one bit per synapse; a clear bit masks its weight
//   i_weight [P_S*P_WIDTH]   packed unsigned weights, synapse k at k*P_WIDTH
//   o_sum    [SW]            sum of the selected weights, wide enough never
//                            to overflow
// ---------------------------------------------------------------------------
module weighted_sum
  import snn_pkg::*;
#(
  parameter int P_S     = 42,
  parameter int P_WIDTH = 8,
  parameter int SW      = sum_width(P_S, P_WIDTH)
) (
  input  logic [P_S-1:0]         i_event,
  input  logic [P_S*P_WIDTH-1:0] i_weight,
  output logic [SW-1:0]          o_sum
);

  // Leaves are padded up to a power of two with zeros so every tree level
  // halves cleanly.
  localparam int LV = $clog2(P_S);
  localparam int N2 = 1 << LV;

  genvar l, k;
  for (l = 0; l <= LV; l++) begin : g_lvl
    logic [SW-1:0] n [N2 >> l];
    if (l == 0) begin : g_leaf
      for (k = 0; k < N2; k++) begin : g_k
        if (k < P_S) begin : g_live
          assign n[k] = i_event[k] ? SW'(i_weight[k*P_WIDTH +: P_WIDTH]) : '0;
        end else begin : g_pad
          assign n[k] = '0;
        end
      end
    end else begin : g_add
      for (k = 0; k < (N2 >> l); k++) begin : g_k
        assign n[k] = g_lvl[l-1].n[2*k] + g_lvl[l-1].n[2*k+1];
      end
    end
  end

  assign o_sum = g_lvl[LV].n[0];

endmodule

// File: rtl/neuron_lif.sv
// ---------------------------------------------------------------------------
// neuron_lif
// Parametrised leaky integrate-and-fire neuron with shift-based periodic leak,
// saturating integration, spike with reset-to-zero and a programmable
// refractory period.
// Optional feature: define NEURON_LIF_SPIKE_CNT_EN to build a saturating
// 16-bit spike counter on o_spike_cnt; otherwise o_spike_cnt is tied to 0.
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_clr        synchronous clear of membrane, counters and state
//   i_event      one-cycle event per synapse
//   i_weight     packed per-synapse unsigned weights
//   i_threshold  firing threshold (sampled live)
//   i_refrac     refractory length in cycles (sampled at spike)
//   o_sv         membrane potential register
//   o_spike      one-cycle registered spike pulse
//   o_refrac     high while refractory
//   o_spike_cnt  spike count (feature-dependent)
// ---------------------------------------------------------------------------
module neuron_lif
  import snn_pkg::*;
#(
  parameter int P_S           = 42,
  parameter int P_WIDTH       = 8,
  parameter int P_VW          = 20,
  parameter int P_LEAK_SHIFT  = 4,
  parameter int P_LEAK_PERIOD = 16,
  parameter int P_RW          = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clr,
  input  logic [P_S-1:0]         i_event,
  input  logic [P_S*P_WIDTH-1:0] i_weight,
  input  logic [P_VW-1:0]        i_threshold,
  input  logic [P_RW-1:0]        i_refrac,
  output logic [P_VW-1:0]        o_sv,
  output logic                   o_spike,
  output logic                   o_refrac,
  output logic [15:0]            o_spike_cnt
);

  localparam int SW  = sum_width(P_S, P_WIDTH);
  localparam int LCW = (P_LEAK_PERIOD > 1) ? $clog2(P_LEAK_PERIOD) : 1;

  state_t          state, state_nxt;
  logic [P_VW-1:0] v, v_nxt;
  logic [P_RW-1:0] rc, rc_nxt;
  logic [LCW-1:0]  lc, lc_nxt;
  logic            spike, spike_nxt;

  logic [SW-1:0]   sum;
  logic            strobe;
  logic [P_VW-1:0] leak;
  logic [P_VW-1:0] v_leak;
  logic [P_VW-1:0] v_int;

  weighted_sum #(
    .P_S     (P_S),
    .P_WIDTH (P_WIDTH),
    .SW      (SW)
  ) u_sum (
    .i_event  (i_event),
    .i_weight (i_weight),
    .o_sum    (sum)
  );

  assign strobe = (lc == LCW'(P_LEAK_PERIOD - 1));
  assign leak   = strobe ? (v >> P_LEAK_SHIFT) : '0;
  // The leak is a fraction of v itself, so this subtraction cannot underflow.
  assign v_leak = v - leak;
  assign v_int  = P_VW'(sat_add(SAT_W'(v_leak), SAT_W'(sum), P_VW));

  // Next-state, membrane and counter logic; i_clr overrides everything.
  always_comb begin
    state_nxt = state;
    v_nxt     = v;
    rc_nxt    = rc;
    spike_nxt = 1'b0;
    lc_nxt    = strobe ? '0 : lc + LCW'(1);
    if (i_clr) begin
      state_nxt = INTEG;
      v_nxt     = '0;
      rc_nxt    = '0;
      lc_nxt    = '0;
    end else begin
      case (state)
        INTEG: begin
          if (v_int >= i_threshold) begin
            spike_nxt = 1'b1;
            v_nxt     = '0;
            rc_nxt    = i_refrac;
            // A zero refractory length fires without leaving INTEG.
            if (i_refrac != '0) state_nxt = REFRACT;
          end else begin
            v_nxt = v_int;
          end
        end
        REFRACT: begin
          // Events are dropped here, including on the cycle of return.
          v_nxt = '0;
          if (rc <= P_RW'(1)) begin
            state_nxt = INTEG;
            rc_nxt    = '0;
          end else begin
            rc_nxt = rc - P_RW'(1);
          end
        end
        default: begin
          state_nxt = INTEG;
          v_nxt     = '0;
          rc_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= INTEG;
      v     <= '0;
      rc    <= '0;
      lc    <= '0;
      spike <= 1'b0;
    end else begin
      state <= state_nxt;
      v     <= v_nxt;
      rc    <= rc_nxt;
      lc    <= lc_nxt;
      spike <= spike_nxt;
    end
  end

  assign o_sv     = v;
  assign o_spike  = spike;
  assign o_refrac = (state == REFRACT);

`ifdef NEURON_LIF_SPIKE_CNT_EN
  logic [15:0] spike_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      spike_cnt <= '0;
    end else if (i_clr) begin
      spike_cnt <= '0;
    end else if (spike_nxt && (spike_cnt != 16'hFFFF)) begin
      spike_cnt <= spike_cnt + 16'd1;
    end
  end

  assign o_spike_cnt = spike_cnt;
`else
  assign o_spike_cnt = '0;
`endif

endmodule

// File: tb/tb_neuron_lif.sv
// ---------------------------------------------------------------------------
// tb_neuron_lif
// Randomised and directed stimulus for neuron_lif, checked against a
// behavioural model that tracks the membrane as an integer, the refractory
// period as "cycles left" and the leak phase as a cycle index mod period.
// ---------------------------------------------------------------------------
module tb_neuron_lif;

  localparam int P_S           = 42;
  localparam int P_WIDTH       = 8;
  localparam int P_VW          = 20;
  localparam int P_LEAK_SHIFT  = 4;
  localparam int P_LEAK_PERIOD = 16;
  localparam int P_RW          = 8;
  localparam longint VMAX      = (longint'(1) << P_VW) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   clr;
  logic [P_S-1:0]         ev;
  logic [P_S*P_WIDTH-1:0] wbus;
  logic [P_VW-1:0]        thr;
  logic [P_RW-1:0]        refr;
  logic [P_VW-1:0]        sv;
  logic                   spike;
  logic                   refrac;
  logic [15:0]            spike_cnt;

  always #5 clk = ~clk;

  neuron_lif #(
    .P_S           (P_S),
    .P_WIDTH       (P_WIDTH),
    .P_VW          (P_VW),
    .P_LEAK_SHIFT  (P_LEAK_SHIFT),
    .P_LEAK_PERIOD (P_LEAK_PERIOD),
    .P_RW          (P_RW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clr       (clr),
    .i_event     (ev),
    .i_weight    (wbus),
    .i_threshold (thr),
    .i_refrac    (refr),
    .o_sv        (sv),
    .o_spike     (spike),
    .o_refrac    (refrac),
    .o_spike_cnt (spike_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  longint m_v;
  int     m_left;
  int     m_phase;
  int     m_cnt;
  bit     m_spike;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_v     = 0;
    m_left  = 0;
    m_phase = 0;
    m_cnt   = 0;
    m_spike = 0;
  endtask

  task automatic model_step();
    longint s;
    longint nv;
    bit     strobe;
    if (clr) begin
      model_reset();
      return;
    end
    strobe = (m_phase == P_LEAK_PERIOD - 1);
    m_phase = (m_phase + 1) % P_LEAK_PERIOD;
    if (m_left > 0) begin
      m_left--;
      m_v     = 0;
      m_spike = 0;
    end else begin
      s = 0;
      for (int k = 0; k < P_S; k++)
        if (ev[k]) s += longint'(wbus[k*P_WIDTH +: P_WIDTH]);
      nv = m_v - (strobe ? (m_v >> P_LEAK_SHIFT) : 0) + s;
      if (nv > VMAX) nv = VMAX;
      if (nv >= longint'(thr)) begin
        m_spike = 1;
        m_v     = 0;
        m_left  = int'(refr);
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_v     = nv;
        m_spike = 0;
      end
    end
  endtask

  task automatic check_outs(input string tag);
    int exp_cnt;
`ifdef NEURON_LIF_SPIKE_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    chk({tag, "_sv"},     64'(sv),        64'(m_v));
    chk({tag, "_spike"},  64'(spike),     64'(m_spike));
    chk({tag, "_refrac"}, 64'(refrac),    64'(m_left > 0));
    chk({tag, "_cnt"},    64'(spike_cnt), 64'(exp_cnt));
  endtask

  // One clock: model advances on the edge, outputs are sampled 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outs(tag);
  endtask

  task automatic set_all_weights(input int w);
    for (int k = 0; k < P_S; k++) wbus[k*P_WIDTH +: P_WIDTH] = P_WIDTH'(w);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    ev  = '0;
    cycle("clr");
    clr = 1'b0;
  endtask

  bit seen;

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    ev    = '0;
    wbus  = '0;
    thr   = '0;
    refr  = '0;
    model_reset();
    #12;
    check_outs("rst");
    rst_n = 1'b1;

    // idle: no events for 100 cycles
    thr = P_VW'(1000);
    refr = P_RW'(3);
    for (int i = 0; i < 100; i++) cycle("idle");

    // integrate to threshold with refractory period 3
    do_clr();
    set_all_weights(10);
    ev = '1;
    cycle("dir");
    chk("dir_v1", 64'(sv), 64'd420);
    cycle("dir");
    chk("dir_v2", 64'(sv), 64'd840);
    cycle("dir");
    chk("dir_fire_sv", 64'(sv), 64'd0);
    chk("dir_fire_spike", 64'(spike), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("dir_refrac_hi", 64'(refrac), 64'd1);
      cycle("dir");
    end
    chk("dir_refrac_lo", 64'(refrac), 64'd0);
    chk("dir_ret_sv", 64'(sv), 64'd0);
    cycle("dir");
    chk("dir_resume", 64'(sv), 64'd420);
    for (int i = 0; i < 10; i++) cycle("dir");

    // leak: single 255 event, threshold max
    thr = P_VW'(VMAX);
    do_clr();
    wbus[0 +: P_WIDTH] = 8'd255;
    ev = '0;
    ev[0] = 1'b1;
    cycle("leak");
    ev = '0;
    for (int i = 0; i < 15; i++) cycle("leak");
    chk("leak_first", 64'(sv), 64'd240);
    for (int i = 0; i < 16; i++) cycle("leak");
    chk("leak_second", 64'(sv), 64'd225);

    // saturation: all weights 255 every cycle
    do_clr();
    set_all_weights(255);
    ev = '1;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      cycle("sat");
      if (spike) seen = 1;
    end
    chk("sat_spike_seen", 64'(seen), 64'd1);
    chk("sat_fire_sv", 64'(sv), 64'd0);
    ev = '0;
    for (int i = 0; i < 5; i++) cycle("sat");

    // zero refractory: spike on consecutive cycles
    do_clr();
    thr  = P_VW'(5);
    refr = '0;
    set_all_weights(0);
    wbus[3*P_WIDTH +: P_WIDTH] = 8'd5;
    ev = '0;
    ev[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle("r0");
      chk("r0_spike", 64'(spike), 64'd1);
      chk("r0_refrac", 64'(refrac), 64'd0);
    end
    ev = '0;
    cycle("r0");

    // i_clr mid-refractory
    set_all_weights(10);
    thr  = P_VW'(100);
    refr = P_RW'(4);
    ev   = '1;
    cycle("mclr");
    ev = '0;
    cycle("mclr");
    cycle("mclr");
    chk("mclr_in_refrac", 64'(refrac), 64'd1);
    clr = 1'b1;
    cycle("mclr");
    clr = 1'b0;
    chk("mclr_out", 64'(refrac), 64'd0);
    ev = '1;
    cycle("mclr");
    chk("mclr_resume", 64'(spike), 64'd1);
    ev = '0;

    // asynchronous reset mid-refractory
    cycle("arst");
    chk("arst_in_refrac", 64'(refrac), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("arst_now");
    #1;
    rst_n = 1'b1;
    ev = '1;
    cycle("arst");
    chk("arst_resume", 64'(spike), 64'd1);
    ev = '0;

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0)
        for (int k = 0; k < P_S; k++) wbus[k*P_WIDTH +: P_WIDTH] = P_WIDTH'($urandom_range(0, 255));
      if (i % 23 == 0)
        thr = ($urandom_range(0, 15) == 0) ? '0 : P_VW'($urandom_range(1, 6000));
      if (i % 17 == 0) refr = P_RW'($urandom_range(0, 6));
      ev  = P_S'({$urandom, $urandom}) & P_S'({$urandom, $urandom}) & P_S'({$urandom, $urandom});
      clr = ($urandom_range(0, 99) == 0);
      cycle("rnd");
    end
    clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
